// File: rtl/pst_conv_sequencer_pkg.sv
// Shared types and defaults for the predictive-spiking convergence sequencer
// and the pst_2layer benches that reuse the same convergence criteria.
package pst_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_RUN    = 3'd2,
        ST_REPORT = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_e;

    localparam int          RES_CYC_W   = 8;
    localparam int          CUR_W       = 8;
    localparam int          DEF_NPAT    = 8;
    localparam logic [7:0]  DEF_CONV_TH = 8'd5;
    localparam logic [3:0]  DEF_HOLD    = 4'd3;
    localparam logic [3:0]  DEF_SETTLE  = 4'd2;
    localparam logic [7:0]  DEF_MAX_CYC = 8'd255;

endpackage

// File: rtl/pst_conv_detect.sv
// Settle/hold/gamma-cycle counters for one pattern; flags are combinational
// on the sampling clock so the FSM can leave RUN on that same edge.
module pst_conv_detect
    import pst_seq_pkg::*;
#(
    parameter logic [7:0] CONV_TH = DEF_CONV_TH,
    parameter logic [3:0] HOLD    = DEF_HOLD,
    parameter logic [3:0] SETTLE  = DEF_SETTLE,
    parameter logic [7:0] MAX_CYC = DEF_MAX_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_i,
    input  logic       sample_i,
    input  logic [7:0] error_i,
    output logic [7:0] cyc_o,
    output logic       converged_o,
    output logic       timeout_o
);

    logic [7:0] cyc_q, cyc_d;
    logic [3:0] hold_q, hold_d;
    logic [3:0] settle_q, settle_d;

    always_comb begin
        cyc_d       = cyc_q;
        hold_d      = hold_q;
        settle_d    = settle_q;
        converged_o = 1'b0;
        timeout_o   = 1'b0;
        if (clear_i) begin
            cyc_d    = '0;
            hold_d   = '0;
            settle_d = '0;
        end else if (sample_i) begin
            cyc_d = (cyc_q == 8'hFF) ? cyc_q : cyc_q + 8'd1;
            if (settle_q < SETTLE) begin
                settle_d = settle_q + 4'd1;
            end else if (error_i <= CONV_TH) begin
                hold_d = hold_q + 4'd1;
            end else begin
                hold_d = '0;
            end
            // Convergence wins over timeout when both land on one sample.
            converged_o = (hold_d == HOLD);
            timeout_o   = !converged_o && (cyc_d == MAX_CYC);
        end
    end

    assign cyc_o = cyc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q    <= '0;
            hold_q   <= '0;
            settle_q <= '0;
        end else begin
            cyc_q    <= cyc_d;
            hold_q   <= hold_d;
            settle_q <= settle_d;
        end
    end

endmodule

// File: rtl/pst_conv_sequencer.sv
// Steps through a table of input currents, measures gamma cycles until the
// layer-2 error converges, and reports latency or timeout per pattern.
module pst_conv_sequencer
    import pst_seq_pkg::*;
#(
    parameter int unsigned NPAT    = DEF_NPAT,
    parameter logic [7:0]  CONV_TH = DEF_CONV_TH,
    parameter logic [3:0]  HOLD    = DEF_HOLD,
    parameter logic [3:0]  SETTLE  = DEF_SETTLE,
    parameter logic [7:0]  MAX_CYC = DEF_MAX_CYC,
    localparam int         AW      = $clog2(NPAT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pat_we,
    input  logic [AW-1:0]        pat_addr,
    input  logic [CUR_W-1:0]     pat_data,
    input  logic [AW:0]          num_pat,
    input  logic                 freeze_mode,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 cycle_start,
    input  logic [7:0]           error_L2,
    output logic [CUR_W-1:0]     input_current,
    output logic                 l3_freeze,
    output logic                 busy,
    output logic                 res_valid,
    output logic [AW-1:0]        res_idx,
    output logic [RES_CYC_W-1:0] res_cycles,
    output logic                 res_timeout,
    output logic                 done,
    output logic [2:0]           dbg_state
);

    localparam logic [AW-1:0] IDX_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    seq_state_e state_q, state_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic [AW:0]          num_q, num_d;
    logic                 frz_q, frz_d;
    logic [CUR_W-1:0]     cur_q;
    logic [AW-1:0]        res_idx_q;
    logic [RES_CYC_W-1:0] res_cyc_q;
    logic                 res_tmo_q;
    logic [CUR_W-1:0]     pat_mem_q [NPAT];

    logic       det_clear, det_sample, det_conv, det_tmo;
    logic [7:0] det_cyc;

    pst_conv_detect #(
        .CONV_TH(CONV_TH), .HOLD(HOLD), .SETTLE(SETTLE), .MAX_CYC(MAX_CYC)
    ) u_detect (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (det_clear),
        .sample_i   (det_sample),
        .error_i    (error_L2),
        .cyc_o      (det_cyc),
        .converged_o(det_conv),
        .timeout_o  (det_tmo)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        num_d      = num_q;
        frz_d      = frz_q;
        det_clear  = 1'b0;
        det_sample = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_d   = num_pat;
                    frz_d   = freeze_mode;
                    idx_d   = '0;
                    state_d = (num_pat == '0) ? ST_DONE : ST_ARM;
                end
            end
            ST_ARM: begin
                // The boundary that ends ARM only restarts the counters.
                if (cycle_start) begin
                    det_clear = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                det_sample = cycle_start;
                if (det_conv || det_tmo) state_d = ST_REPORT;
            end
            ST_REPORT: begin
                if (({1'b0, idx_q} + CNT_ONE) == num_q) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = ST_ARM;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort && state_q != ST_IDLE) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            num_q     <= '0;
            frz_q     <= 1'b0;
            cur_q     <= '0;
            res_idx_q <= '0;
            res_cyc_q <= '0;
            res_tmo_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            frz_q   <= frz_d;
            if (state_q == ST_ARM) cur_q <= pat_mem_q[idx_q];
            if (state_q == ST_RUN && state_d == ST_REPORT) begin
                res_idx_q <= idx_q;
                res_cyc_q <= det_cyc;
                res_tmo_q <= det_tmo;
            end
        end
    end

    // Table is deliberately not reset; it is only writable while idle.
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && pat_we) pat_mem_q[pat_addr] <= pat_data;
    end

    assign input_current = cur_q;
    assign l3_freeze     = frz_q;
    assign busy          = (state_q != ST_IDLE);
    assign res_valid     = (state_q == ST_REPORT) && !abort;
    assign done          = (state_q == ST_DONE) && !abort;
    assign res_idx       = res_idx_q;
    assign res_cycles    = res_cyc_q;
    assign res_timeout   = res_tmo_q;
    assign dbg_state     = state_q;

endmodule

// File: doc/pst_conv_sequencer.md
Name: pst_conv_sequencer

Overview:
Experiment sequencer for the two-layer predictive spiking stack (pst_2layer). It steps through a small table of input-current patterns, drives input_current and l3_freeze, counts gamma cycles (cycle_start pulses) until the layer-2 error converges, and reports convergence latency or timeout per pattern. Sits between the gamma_oscillator/pst_2layer pair and a host or testbench, replacing hand-written stimulus loops.

Parameters:
NPAT, 8, pattern table depth (power of 2).
CONV_TH, 5, error_L2 <= CONV_TH counts as converged.
HOLD, 3, consecutive converged samples required (1..15).
SETTLE, 2, samples ignored after each pattern switch.
MAX_CYC, 255, gamma cycles before timeout (8-bit).

Ports:
clk  in  1  system clock
rst_n  in  1  async active-low reset
pat_we  in  1  table write strobe (accepted only in IDLE)
pat_addr  in  log2(NPAT)  table write address
pat_data  in  8  input_current value to store
num_pat  in  log2(NPAT)+1  patterns to run (0 = none), latched at start
freeze_mode  in  1  value driven on l3_freeze for whole run, latched at start
start  in  1  one-cycle pulse, begin run (ignored unless IDLE)
abort  in  1  return to IDLE next clock
cycle_start  in  1  gamma cycle boundary pulse
error_L2  in  8  layer-2 prediction error magnitude
input_current  out  8  current to pst_2layer
l3_freeze  out  1  freeze control to pst_2layer
busy  out  1  high outside IDLE
res_valid  out  1  one-cycle result pulse
res_idx  out  log2(NPAT)  pattern index of result
res_cycles  out  8  gamma cycles to convergence (or MAX_CYC on timeout)
res_timeout  out  1  result is a timeout
done  out  1  one-cycle pulse after last result

Behaviour:
- Reset: all outputs 0, table contents undefined (not cleared), FSM IDLE.
- States: IDLE, ARM, RUN, REPORT, DONE.
- IDLE: pat_we writes table synchronously. start with num_pat=0 -> DONE directly. start otherwise: latch num_pat, freeze_mode; idx=0; -> ARM.
- ARM: input_current = table[idx] (registered, valid from the cycle after entry); wait for cycle_start; on it clear cyc_cnt, hold_cnt, settle_cnt -> RUN. The cycle_start that ends ARM is not sampled.
- RUN, on each cycle_start: cyc_cnt += 1 (saturate at 255). If settle_cnt < SETTLE: settle_cnt += 1, no check. Else if error_L2 <= CONV_TH: hold_cnt += 1, else hold_cnt = 0. hold_cnt reaching HOLD -> REPORT, converged. Else cyc_cnt == MAX_CYC -> REPORT, timeout. Converged is checked before timeout on the same sample.
- res_cycles = cyc_cnt at the sample where HOLD was reached (first-crossing latency = res_cycles - HOLD + 1 for host use).
- REPORT: one clock; res_valid=1 with res_idx/res_cycles/res_timeout; res_* hold until the next res_valid. If idx+1 == num_pat -> DONE, else idx += 1 -> ARM.
- DONE: done pulses 1 clock -> IDLE. input_current holds its last value and l3_freeze holds latched freeze_mode until next start.
- error_L2 is sampled only on the cycle_start clock, with no synchronisation (same clock domain).
- abort in any non-IDLE state: -> IDLE next clock, no res_valid, no done, input_current retained. abort takes priority over all transitions.
- start while busy is ignored. pat_we while busy is ignored (no table change mid-run).
- Async reset mid-run: immediate IDLE, outputs 0.
- cycle_start in the same clock as a state entry into RUN is handled per ARM rule only. No double counting.

Decomposition:
- Package pst_seq_pkg: state enum, result record width constants, CONV/HOLD defaults shared with pst_2layer benches.
- Sub-module pst_conv_detect: settle/hold/cycle counters plus converged/timeout flags, cleared by the FSM. Table is a plain register array in the top.

Test Plan:
- Single pattern 50, error_L2 model 40 falling 5 per gamma cycle, HOLD=3, SETTLE=2 -> res_valid once, res_cycles=10, res_timeout=0, then done. input_current=50 throughout.
- error_L2 fixed at 20, MAX_CYC=16 -> res_timeout=1, res_cycles=16.
- Hold reset: errors ...4,4,9,4,4,4 after settle -> convergence only on the third 4 of the final run.
- Three patterns 50,10,200, num_pat=3, freeze_mode=1 -> three results idx 0,1,2, input_current switches only in ARM, l3_freeze=1 whole run, one done.
- abort during RUN of idx 1 -> IDLE next clock, busy=0, no res_valid/done. New start reruns from idx 0.
- num_pat=0 start -> done pulse 2 clocks later, no res_valid. start and pat_we while busy -> no effect.
